// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle for the PS/2 host transmitter.
// The master side offers bytes; the slave side (transmitter) reports status.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       err_timeout;
   logic       err_nack;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  busy,
      input  done,
      input  err_timeout,
      input  err_nack
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output busy,
      output done,
      output err_timeout,
      output err_nack
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, RTS, 11 device clocks, ACK).
// Define PS2_ACK_CHECK_EN to flag a missing device ACK on err_nack.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic clk_board,
   input  logic reset,
   ps2_host_tx_if.slave tx,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic ps2_clk_oe,
   output logic ps2_data_oe
);

   localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                         INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, RTS, BITS, WAIT_IDLE
   } state_t;

   state_t state, state_d;

   logic          clk_meta, clk_sync, clk_prev;
   logic          data_meta, data_sync;
   logic          fall;
   logic [7:0]    shift;
   logic          parity;
   logic [3:0]    bit_idx;
   logic [CW-1:0] cnt, cnt_d;
   logic          data_q;
   logic          done_q;
   logic          err_timeout_q;
   logic          accept;
   logic          timeout;
   logic          finish;

   // Idle lines read high, so the synchroniser resets to 1 to avoid a false fall.
   always_ff @(posedge clk_board) begin
      if (reset) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk_in;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= ps2_data_in;
         data_sync <= data_meta;
      end
   end

   assign fall = clk_prev & ~clk_sync;

   always_ff @(posedge clk_board) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      timeout = 1'b0;
      finish  = 1'b0;
      cnt_d   = cnt + CNT_ONE;
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            if (tx.tx_valid && !done_q) begin
               accept  = 1'b1;
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt == INH_LAST) begin
               cnt_d   = '0;
               state_d = RTS;
            end
         end
         RTS: begin
            cnt_d   = '0;
            state_d = BITS;
         end
         BITS: begin
            if (fall) begin
               cnt_d = '0;
               if (bit_idx == 4'd10) state_d = WAIT_IDLE;
            end else if (cnt == TMO_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
               finish  = 1'b1;
               state_d = IDLE;
            end else if (fall) begin
               cnt_d = '0;
            end else if (cnt == TMO_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_board) begin
      if (reset) begin
         cnt           <= '0;
         shift         <= '0;
         parity        <= 1'b0;
         bit_idx       <= '0;
         data_q        <= 1'b0;
         done_q        <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         cnt    <= cnt_d;
         done_q <= timeout | finish;
         if (accept) begin
            shift         <= tx.tx_data;
            parity        <= ~^tx.tx_data;
            bit_idx       <= '0;
            err_timeout_q <= 1'b0;
         end
         if (timeout) err_timeout_q <= 1'b1;
         if (state == RTS) begin
            data_q  <= 1'b1;
            bit_idx <= '0;
         end
         // Each fall presents the next frame bit: data, parity, then stop.
         if (state == BITS && fall && bit_idx != 4'd10) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx < 4'd8)       data_q <= ~shift[bit_idx[2:0]];
            else if (bit_idx == 4'd8) data_q <= ~parity;
            else                      data_q <= 1'b0;
         end
      end
   end

`ifdef PS2_ACK_CHECK_EN
   logic err_nack_q;

   always_ff @(posedge clk_board) begin
      if (reset) begin
         err_nack_q <= 1'b0;
      end else if (accept) begin
         err_nack_q <= 1'b0;
      end else if (state == BITS && fall && bit_idx == 4'd10) begin
         err_nack_q <= data_sync;
      end
   end

   assign tx.err_nack = err_nack_q;
`else
   assign tx.err_nack = 1'b0;
`endif

   assign tx.tx_ready    = (state == IDLE) & ~done_q;
   assign tx.busy        = (state != IDLE);
   assign tx.done        = done_q;
   assign tx.err_timeout = err_timeout_q;

   assign ps2_clk_oe  = (state == INHIBIT) | (state == RTS);
   assign ps2_data_oe = (state == RTS) | ((state == BITS) & data_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model, vector table and corner sequences.
// Short inhibit/timeout parameters keep the run small.
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TMO  = 300;
   localparam int HALF = 8;

`ifdef PS2_ACK_CHECK_EN
   localparam logic NACK_ON = 1'b1;
`else
   localparam logic NACK_ON = 1'b0;
`endif

   logic clk_board = 1'b0;
   logic reset;
   logic ps2_clk_in, ps2_data_in;
   logic ps2_clk_oe, ps2_data_oe;
   logic dev_clk, dev_data;

   int pass_cnt = 0;
   int total_cnt = 0;
   int done_pulses = 0;

   ps2_host_tx_if ifc ();

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_board   (clk_board),
      .reset       (reset),
      .tx          (ifc.slave),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   // Open-collector bus: either side pulling low wins.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk);
   assign ps2_data_in = ~(ps2_data_oe | dev_data);

   always #5 clk_board = ~clk_board;

   always @(negedge clk_board) if (ifc.done === 1'b1) done_pulses++;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic send(input logic [7:0] d, input logic ack,
                       input bit hold, input int abort_k,
                       input logic [9:0] exp_frame, input logic exp_nack);
      int n;
      int d0;
      bit got;
      logic [9:0] rx;
      rx = '0;
      d0 = done_pulses;
      @(negedge clk_board);
      ifc.tx_data  = d;
      ifc.tx_valid = 1'b1;
      @(negedge clk_board);
      chk("accept_busy", ifc.busy, 1);
      if (hold) ifc.tx_data = 8'h77;
      else      ifc.tx_valid = 1'b0;
      n = 0;
      while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
         n++;
         @(negedge clk_board);
      end
      chk("inhibit_len", n, INH);
      chk("rts_clk_oe", ps2_clk_oe, 1);
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) dev_data = ~ack;
         repeat (HALF) @(negedge clk_board);
         dev_clk = 1'b1;
         if (k == abort_k) begin
            repeat (6) @(negedge clk_board);
            reset = 1'b1;
            @(negedge clk_board);
            chk("abort_clk_oe", ps2_clk_oe, 0);
            chk("abort_data_oe", ps2_data_oe, 0);
            chk("abort_ready", ifc.tx_ready, 1);
            reset        = 1'b0;
            dev_clk      = 1'b0;
            dev_data     = 1'b0;
            ifc.tx_valid = 1'b0;
            repeat (5) @(negedge clk_board);
            return;
         end
         repeat (HALF) @(negedge clk_board);
         dev_clk = 1'b0;
         if (k <= 10) rx[k-1] = ps2_data_in;
      end
      dev_data = 1'b0;
      chk("frame", rx, exp_frame);
      n = 0;
      got = 0;
      while (!got && n < 200) begin
         @(negedge clk_board);
         n++;
         if (ifc.done === 1'b1) got = 1;
      end
      ifc.tx_valid = 1'b0;
      chk("done_seen", got, 1);
      chk("err_timeout", ifc.err_timeout, 0);
      chk("err_nack", ifc.err_nack, exp_nack);
      chk("ready_in_done", ifc.tx_ready, 0);
      @(negedge clk_board);
      chk("ready_after", ifc.tx_ready, 1);
      chk("done_count", done_pulses - d0, 1);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       ack;
      bit         hold;
      logic [9:0] frame;
      logic       nack;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int n;
      int d0;
      // frame = {stop, odd parity, data LSB..MSB}
      vecs[0] = '{8'hED, 1'b0, 1'b0, 10'h3ED, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 10'h201, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 1'b0, 10'h3FF, 1'b0};
      vecs[3] = '{8'hF4, 1'b1, 1'b0, 10'h2F4, NACK_ON};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 10'h300, 1'b0};

      reset        = 1'b1;
      ifc.tx_valid = 1'b0;
      ifc.tx_data  = '0;
      dev_clk      = 1'b0;
      dev_data     = 1'b0;
      repeat (3) @(negedge clk_board);
      chk("rst_ready", ifc.tx_ready, 1);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_errs", {ifc.err_timeout, ifc.err_nack}, 0);
      chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk_board);

      for (int i = 0; i < 5; i++)
         send(vecs[i].d, vecs[i].ack, vecs[i].hold, 0,
              vecs[i].frame, vecs[i].nack);

      // Silent device: timeout counted from BITS entry.
      d0 = done_pulses;
      @(negedge clk_board);
      ifc.tx_data  = 8'hFF;
      ifc.tx_valid = 1'b1;
      @(negedge clk_board);
      ifc.tx_valid = 1'b0;
      chk("to_err_cleared", ifc.err_nack, 0);
      n = 0;
      while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
         n++;
         @(negedge clk_board);
      end
      chk("to_inhibit_len", n, INH);
      @(negedge clk_board);
      chk("to_bits_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      n = 0;
      while (ifc.err_timeout !== 1'b1 && n < TMO + 50) begin
         @(negedge clk_board);
         n++;
      end
      chk("to_cycles", n, TMO);
      chk("to_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("to_done", ifc.done, 1);
      @(negedge clk_board);
      chk("to_ready", ifc.tx_ready, 1);
      chk("to_done_count", done_pulses - d0, 1);

      send(8'hAA, 1'b0, 1'b0, 5, 10'h3AA, 1'b0);
      chk("abort_err_timeout", ifc.err_timeout, 0);
      send(8'h55, 1'b0, 1'b0, 0, 10'h355, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
